// File: rtl/noc_ingress_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_ingress_arbiter_if
//
// Bundle of every handshake and payload signal between the CPU ports, the
// ingress arbiter and the NoC core.
//
// Parameters
//   CPU_NB : number of CPU request ports (2..16)
//   DATA_W : flit width in bits
//
// Signals
//   data_cpu_to_noc_vld [CPU_NB]         CPU -> arbiter  per-CPU flit valid
//   data_cpu_to_noc_rdy [CPU_NB]         arbiter -> CPU  per-CPU flit accepted
//   data_cpu_to_noc     [CPU_NB][DATA_W] CPU -> arbiter  per-CPU payload
//   noc_in_vld                           arbiter -> NoC  merged flit valid
//   noc_in_rdy                           NoC -> arbiter  merged flit accepted
//   noc_in_data         [DATA_W]         arbiter -> NoC  merged payload
//   noc_in_src          [SRC_W]          arbiter -> NoC  index of source CPU
//
// Modports
//   master : the arbiter; it drives the merged flit and the per-CPU ready.
//   slave  : the surroundings (CPUs plus NoC core).
// ---------------------------------------------------------------------------
interface noc_ingress_arbiter_if #(
    parameter int CPU_NB = 4,
    parameter int DATA_W = 64
);
    localparam int SRC_W = $clog2(CPU_NB);

    logic [CPU_NB-1:0]             data_cpu_to_noc_vld;
    logic [CPU_NB-1:0]             data_cpu_to_noc_rdy;
    logic [CPU_NB-1:0][DATA_W-1:0] data_cpu_to_noc;
    logic                          noc_in_vld;
    logic                          noc_in_rdy;
    logic [DATA_W-1:0]             noc_in_data;
    logic [SRC_W-1:0]              noc_in_src;

    modport master (
        input  data_cpu_to_noc_vld,
        input  data_cpu_to_noc,
        input  noc_in_rdy,
        output data_cpu_to_noc_rdy,
        output noc_in_vld,
        output noc_in_data,
        output noc_in_src
    );

    modport slave (
        output data_cpu_to_noc_vld,
        output data_cpu_to_noc,
        output noc_in_rdy,
        input  data_cpu_to_noc_rdy,
        input  noc_in_vld,
        input  noc_in_data,
        input  noc_in_src
    );
endinterface

// File: rtl/noc_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// noc_ingress_arbiter
//
// Merges CPU_NB valid/ready flit streams into one stream toward the NoC core.
// A single registered output slot holds the merged flit; it reloads on any
// cycle where it is empty or being drained, so a flit can pass every cycle.
// Among requesting CPUs the one picked is the first index at or after
// last_grant+1 (wrapping), which bounds every CPU's wait to CPU_NB-1 grants
// of other CPUs.
//
// Ports
//   clk   : single clock, rising edge
//   rst   : asynchronous, active-high reset
//   bus   : noc_ingress_arbiter_if.master
//           in : data_cpu_to_noc_vld, data_cpu_to_noc, noc_in_rdy
//           out: data_cpu_to_noc_rdy, noc_in_vld, noc_in_data, noc_in_src
//
// Timing
//   noc_in_vld/data/src come straight from flops (no path from noc_in_rdy).
//   data_cpu_to_noc_rdy is combinational from the vld inputs, noc_in_rdy and
//   the registered state.
//   A CPU flit accepted at edge N appears on noc_in_* after edge N.
//   No flit is accepted on the first edge after rst is released.
// ---------------------------------------------------------------------------
module noc_ingress_arbiter #(
    parameter int CPU_NB = 4,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    noc_ingress_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(CPU_NB);

    // HOLD covers the edge right after reset release: nothing is accepted
    // until the arbiter has seen one clean clock edge out of reset.
    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q,      state_d;
    logic              out_vld_q,    out_vld_d;
    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic [SRC_W-1:0]  out_src_q,    out_src_d;
    logic [SRC_W-1:0]  last_grant_q, last_grant_d;

    logic              slot_can_load;
    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;
    logic              cpu_xfer;
    logic [CPU_NB-1:0] grant_oh;

    // -----------------------------------------------------------------------
    // Round-robin pick. Returns {found, index}. The candidate order runs from
    // last+1 upward with wrap; walking it backwards lets the last hit, i.e.
    // the nearest requester, win without a priority chain of flags.
    // -----------------------------------------------------------------------
    function automatic logic [SRC_W:0] rr_pick(
        input logic [CPU_NB-1:0] req,
        input logic [SRC_W-1:0]  last
    );
        logic [SRC_W:0]   pick;
        logic [SRC_W-1:0] idx;
        int               cand;
        pick = '0;
        for (int k = CPU_NB; k >= 1; k--) begin
            cand = (int'(last) + k) % CPU_NB;
            idx  = SRC_W'(cand);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    assign {grant_found, grant_idx} = rr_pick(bus.data_cpu_to_noc_vld, last_grant_q);

    // The slot can take a new flit when empty or when its current flit leaves
    // on this same edge.
    assign slot_can_load = (state_q == ST_RUN) && (!out_vld_q || bus.noc_in_rdy);
    assign cpu_xfer      = slot_can_load && grant_found;

    always_comb begin
        grant_oh = '0;
        if (cpu_xfer) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign bus.data_cpu_to_noc_rdy = grant_oh;

    // -----------------------------------------------------------------------
    // Next-state logic. Only the granted CPU's payload is ever selected, so
    // unknown data on idle ports cannot reach the slot.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d      = ST_RUN;
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;

        if (cpu_xfer) begin
            out_vld_d    = 1'b1;
            out_data_d   = bus.data_cpu_to_noc[grant_idx];
            out_src_d    = grant_idx;
            last_grant_d = grant_idx;
        end else if (bus.noc_in_rdy) begin
            // Current flit (if any) drains and nothing replaces it.
            out_vld_d = 1'b0;
        end
    end

    // NOTE: the payload register is reset even though it is datapath, because
    // noc_in_data must read zero while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= ST_HOLD;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_W'(CPU_NB - 1);
        end else begin
            state_q      <= state_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.noc_in_vld  = out_vld_q;
    assign bus.noc_in_data = out_data_q;
    assign bus.noc_in_src  = out_src_q;

    // -----------------------------------------------------------------------
    // Protocol properties
    // -----------------------------------------------------------------------
    rdy_onehot_a : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.data_cpu_to_noc_rdy));

    rdy_only_to_requester_a : assert property (@(posedge clk) disable iff (rst)
        (bus.data_cpu_to_noc_rdy & ~bus.data_cpu_to_noc_vld) == '0);

    slot_stable_a : assert property (@(posedge clk) disable iff (rst)
        (out_vld_q && !bus.noc_in_rdy) |=>
            (out_vld_q && $stable(out_data_q) && $stable(out_src_q)));

endmodule

// File: doc/noc_ingress_arbiter.md
NOC_INGRESS_ARBITER -- requirements
Module: noc_ingress_arbiter

Interface
REQ-001 SHALL have parameter CPU_NB, default 4, number of CPU request ports (legal range 2..16).
REQ-002 SHALL have parameter DATA_W, default 64, flit width in bits.
REQ-003 SHALL define SRC_W = $clog2(CPU_NB) as a derived local width, not overridable.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port data_cpu_to_noc_vld, input, CPU_NB x 1, per-CPU flit valid.
REQ-007 SHALL have port data_cpu_to_noc_rdy, output, CPU_NB x 1, per-CPU flit accepted this cycle.
REQ-008 SHALL have port data_cpu_to_noc, input, CPU_NB x DATA_W, per-CPU flit payload.
REQ-009 SHALL have port noc_in_vld, output, 1, merged flit valid toward the NoC core.
REQ-010 SHALL have port noc_in_rdy, input, 1, NoC core accepts the merged flit.
REQ-011 SHALL have port noc_in_data, output, DATA_W, merged flit payload.
REQ-012 SHALL have port noc_in_src, output, SRC_W, index of the CPU that sourced noc_in_data.

Function
REQ-013 SHALL hold one output register slot (noc_in_vld/data/src); a transfer occurs on any edge where valid and ready are both high.
REQ-014 SHALL treat the slot as able to load when noc_in_vld is low or noc_in_rdy is high (full throughput, one flit per cycle).
REQ-015 SHALL select, among CPUs with vld high, the first index at or after (last_grant+1) mod CPU_NB, searching upward with wrap-around.
REQ-016 SHALL assert data_cpu_to_noc_rdy for at most one CPU per cycle: the selected one, and only when the slot can load.
REQ-017 SHALL, on a CPU transfer, load noc_in_data and noc_in_src with the selected payload and index, and set noc_in_vld at the next edge (latency 1 cycle).
REQ-018 SHALL update last_grant to the selected index only on a CPU transfer; no transfer leaves last_grant unchanged.
REQ-019 SHALL clear noc_in_vld at the edge where noc_in_rdy is high and no CPU transfer occurs.
REQ-020 SHALL keep noc_in_vld, noc_in_data and noc_in_src stable while noc_in_vld is high and noc_in_rdy is low.
REQ-021 SHALL produce noc_in_vld independent of noc_in_rdy in the same cycle; data_cpu_to_noc_rdy may depend combinationally on the vld inputs and noc_in_rdy.
REQ-022 SHALL, when all vld inputs are low, assert no rdy and leave last_grant unchanged.
REQ-023 SHALL, when a single CPU requests continuously and the others are idle, grant it every cycle the slot can load.
REQ-024 SHALL guarantee each continuously requesting CPU a grant within CPU_NB accepted transfers.
REQ-025 SHALL ignore data_cpu_to_noc payload of non-granted CPUs; X on those inputs SHALL NOT propagate.

Reset
REQ-026 SHALL, while rst is high, force noc_in_vld=0, noc_in_data=0, noc_in_src=0, all data_cpu_to_noc_rdy=0, and last_grant=CPU_NB-1 so that CPU 0 has first priority.
REQ-027 SHALL, on rst asserted mid-transfer, discard the held flit with no partial output; after deassertion, the first grant follows REQ-026 priority.
REQ-028 SHALL accept no flit in the cycle in which rst is deasserted.

Verification
REQ-029 SHALL cover: after reset, all four CPUs with vld=1, noc_in_rdy=1 -> rdy grants CPU 0,1,2,3,0 on consecutive cycles; noc_in_src follows one cycle later.
REQ-030 SHALL cover: CPU 2 alone sends 0xA5A5_0000_0000_0001, noc_in_rdy=1 -> noc_in_vld=1, data=0xA5A5_0000_0000_0001, src=2 at the next edge.
REQ-031 SHALL cover: slot full with noc_in_rdy=0 for 5 cycles, CPUs 1 and 3 requesting -> no rdy asserted, output frozen; the cycle noc_in_rdy rises, CPU 1 or 3 is granted per pointer and the old flit transfers in the same cycle.
REQ-032 SHALL cover: last_grant=3, requests from CPUs 0 and 3 only -> CPU 0 granted (wrap-around), then CPU 3.
REQ-033 SHALL cover: rst pulsed while noc_in_vld=1 and noc_in_rdy=0 -> noc_in_vld=0 immediately (asynchronous), and CPU 0 is first granted after release.
REQ-034 SHALL cover: random vld/noc_in_rdy for 10k cycles -> scoreboard shows per-CPU in-order, lossless, non-duplicated delivery and no CPU waits more than 4 accepted transfers.
